alu_issue: RTL and testbench
============================

Name: alu_issue

Overview:
- Issue/writeback controller that drives the 8-bit ALU from the instruction side.
- Accepts one decoded ALU instruction per valid/ready handshake and reads its operands from an internal register file.
- Pulses the ALU enable with mode and operands, captures result and flags one cycle later, then writes back.
- Sits between the decode stage and the ALU; owns the architectural Z/C flags.

Parameters:
- N, 8, datapath width; must equal the ALU width.
- NREGS, 4, register count; RW = $clog2(NREGS) is the register address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  controller can accept an instruction.
- instr_op  in  4  opcode: ADD=0, SUB=1, AND=2, OR=3, XOR=4, CMP=5 (CMP only with feature).
- instr_rd  in  RW  destination register.
- instr_ra  in  RW  operand A register.
- instr_rb  in  RW  operand B register.
- instr_use_imm  in  1  B operand taken from instr_imm instead of register rb.
- instr_imm  in  N  immediate value.
- alu_enable  out  1  ALU enable, one-cycle pulse.
- alu_mode  out  4  ALU mode.
- alu_a  out  N  ALU operand A.
- alu_b  out  N  ALU operand B.
- alu_out  in  N  ALU result.
- alu_zero  in  1  ALU zero flag.
- alu_carry  in  1  ALU carry/borrow flag.
- wb_valid  out  1  one-cycle pulse: writeback performed.
- wb_rd  out  RW  register written.
- wb_data  out  N  value written.
- flag_z  out  1  architectural zero flag.
- flag_c  out  1  architectural carry flag.
- err_illegal  out  1  one-cycle pulse: illegal opcode dropped.
- dbg_addr  in  RW  debug read address.
- dbg_data  out  N  combinational read of regs[dbg_addr].

Behaviour:
- Reset (asynchronous, on rst_n low):
  - state=IDLE; all registers, flag_z, flag_c, wb_* and err_illegal = 0.
  - alu_enable=0, alu_mode=0, alu_a=0, alu_b=0.
- State machine: IDLE -> ISSUE -> CAPTURE -> IDLE. One instruction per 3 cycles; no overlap, so no hazards.
- IDLE:
  - instr_ready=1.
  - On instr_valid & instr_ready, latch op/rd/ra/rb/use_imm/imm.
  - Legal op -> ISSUE.
  - Illegal op (>4, or 5 without the feature) -> err_illegal=1 next cycle, stay IDLE, ALU not enabled, no state change.
- ISSUE (instr_ready=0):
  - alu_enable=1 for exactly this cycle.
  - alu_mode = latched op.
  - alu_a = regs[ra].
  - alu_b = use_imm ? imm : regs[rb].
  - Operands are read in this cycle, so a write from the previous instruction is visible.
  - -> CAPTURE.
- CAPTURE (instr_ready=0, alu_enable=0):
  - alu_out and flags are valid, since the ALU registers on the ISSUE edge.
  - On the exiting edge: regs[rd] <= alu_out; wb_valid=1, wb_rd=rd, wb_data=alu_out for one cycle.
  - flag_z <= alu_zero for all ops.
  - flag_c <= alu_carry for ADD/SUB only; AND/OR/XOR preserve flag_c, because the ALU carry output is stale for logic ops.
  - -> IDLE.
- Arithmetic: modulo 2^N. SUB carry is the borrow bit of in_a - in_b (1 when a<b).
- Same register for ra/rb/rd is legal; the read-before-write ordering above applies.
- instr_valid held high while not ready: held, not consumed. instr_ready is never asserted outside IDLE.
- Reset mid-ISSUE or mid-CAPTURE: in-flight instruction dropped; no wb_valid; regs cleared.
- alu_mode/alu_a/alu_b hold their last values when alu_enable=0.

Optional Feature:
- Macro ALU_ISSUE_CMP_EN.
- Defined: op 5 (CMP) is legal. It issues the ALU SUB mode and updates flag_z and flag_c in CAPTURE. Register file not written; wb_valid stays 0.
- Undefined: op 5 is illegal (err_illegal pulse, no ALU activity).

Decomposition:
- Package fluxcore_pkg holds:
  - opcode/mode constants, shared with the ALU so encodings cannot diverge;
  - state enum {IDLE, ISSUE, CAPTURE};
  - default N.
- One natural sub-module, alu_regfile: NREGS x N, async-reset, 2 combinational read ports plus the debug port, 1 synchronous write port.

Test Plan:
- Reset release; imm-load r1 via ADD r1=r0+imm 0x05 -> wb_valid 3 cycles after accept, regs[1]=0x05, flag_z=0, flag_c=0.
- ADD r2=r1+imm 0xFF with r1=0x05 -> wb_data=0x04, flag_c=1, flag_z=0.
- AND r3=r1&imm 0x00 following the carry-setting ADD -> wb_data=0x00, flag_z=1, flag_c remains 1.
- SUB r1=r1-imm 0x06 with r1=0x05 -> wb_data=0xFF, flag_c=1 (borrow); back-to-back valid shows instr_ready low for exactly 2 cycles.
- Opcode 7 offered -> err_illegal pulse, alu_enable never asserted, regs and flags unchanged, instr_ready stays 1.
- rst_n low during CAPTURE -> no wb_valid, dbg_data=0 for all addresses. With ALU_ISSUE_CMP_EN: CMP 0x05 vs 0x05 -> flag_z=1, no writeback.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Package fluxcore_pkg: encodings shared by the ALU issue controller and the ALU.
//
// Contents:
//   - N_DEFAULT        : default datapath width
//   - OP_* constants   : instruction opcodes seen on instr_op
//   - MODE_* constants : ALU mode encodings driven on alu_mode
//   - state_e          : issue controller state encoding
//   - op_to_mode()     : maps an opcode to the ALU mode that executes it
//
// Both the controller and the ALU import this package, so the opcode and
// mode encodings have a single definition and cannot drift apart.
package fluxcore_pkg;

  localparam int N_DEFAULT = 8;

  // Instruction opcodes
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_CMP = 4'd5;

  // ALU modes (identical to the arithmetic/logic opcodes)
  localparam logic [3:0] MODE_ADD = 4'd0;
  localparam logic [3:0] MODE_SUB = 4'd1;
  localparam logic [3:0] MODE_AND = 4'd2;
  localparam logic [3:0] MODE_OR  = 4'd3;
  localparam logic [3:0] MODE_XOR = 4'd4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_e;

  // CMP is a subtraction whose result is discarded; every other legal
  // opcode maps directly onto the mode with the same encoding.
  function automatic logic [3:0] op_to_mode(input logic [3:0] op);
    logic [3:0] mode;
    if (op == OP_CMP) begin
      mode = MODE_SUB;
    end else begin
      mode = op;
    end
    return mode;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: NREGS x N register file for the ALU issue controller.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset (clears all entries)
//   we, waddr, wdata    : synchronous write port
//   raddr_a / rdata_a   : combinational read port A
//   raddr_b / rdata_b   : combinational read port B
//   dbg_addr / dbg_data : combinational debug read port
module alu_regfile
  import fluxcore_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int NREGS = 4,
  parameter int RW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [RW-1:0] waddr,
  input  logic [N-1:0]  wdata,
  input  logic [RW-1:0] raddr_a,
  output logic [N-1:0]  rdata_a,
  input  logic [RW-1:0] raddr_b,
  output logic [N-1:0]  rdata_b,
  input  logic [RW-1:0] dbg_addr,
  output logic [N-1:0]  dbg_data
);

  logic [N-1:0] mem_r [NREGS];

  // Register storage: cleared on reset, one write per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_r[i] <= {N{1'b0}};
      end
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata_a  = mem_r[raddr_a];
  assign rdata_b  = mem_r[raddr_b];
  assign dbg_data = mem_r[dbg_addr];

endmodule

// File: rtl/alu_issue.sv
// alu_issue: issue/writeback controller that drives an N-bit ALU.
//
// Accepts one decoded instruction per instr_valid/instr_ready handshake,
// reads operands from the internal register file, pulses the ALU for one
// cycle, captures result and flags one cycle later and writes back.
// Sequence per instruction: IDLE -> ISSUE -> CAPTURE -> IDLE.
//
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   instr_valid / instr_ready   : instruction handshake (ready only in IDLE)
//   instr_op/rd/ra/rb           : opcode and register addresses
//   instr_use_imm / instr_imm   : select and value of immediate B operand
//   alu_enable/mode/a/b         : ALU request (enable is a one-cycle pulse)
//   alu_out/zero/carry          : ALU response, valid in CAPTURE
//   wb_valid/wb_rd/wb_data      : one-cycle writeback report
//   flag_z / flag_c             : architectural zero/carry flags
//   err_illegal                 : one-cycle pulse when an opcode is dropped
//   dbg_addr / dbg_data         : combinational register file peek
//
// Build option: macro ALU_ISSUE_CMP_EN makes opcode 5 (CMP) legal. CMP
// runs the ALU in SUB mode, updates both flags and writes no register.
// Without the macro opcode 5 is rejected like any other illegal opcode.
module alu_issue
  import fluxcore_pkg::*;
#(
  parameter  int N     = N_DEFAULT,
  parameter  int NREGS = 4,
  localparam int RW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [3:0]    instr_op,
  input  logic [RW-1:0] instr_rd,
  input  logic [RW-1:0] instr_ra,
  input  logic [RW-1:0] instr_rb,
  input  logic          instr_use_imm,
  input  logic [N-1:0]  instr_imm,
  output logic          alu_enable,
  output logic [3:0]    alu_mode,
  output logic [N-1:0]  alu_a,
  output logic [N-1:0]  alu_b,
  input  logic [N-1:0]  alu_out,
  input  logic          alu_zero,
  input  logic          alu_carry,
  output logic          wb_valid,
  output logic [RW-1:0] wb_rd,
  output logic [N-1:0]  wb_data,
  output logic          flag_z,
  output logic          flag_c,
  output logic          err_illegal,
  input  logic [RW-1:0] dbg_addr,
  output logic [N-1:0]  dbg_data
);

  localparam logic [1:0] S_IDLE    = IDLE;
  localparam logic [1:0] S_ISSUE   = ISSUE;
  localparam logic [1:0] S_CAPTURE = CAPTURE;

  logic [1:0]    state_r;
  logic [3:0]    op_r;
  logic [RW-1:0] rd_r;

  logic          rf_we_s;
  logic [N-1:0]  rf_rdata_a_s;
  logic [N-1:0]  rf_rdata_b_s;
  logic          accept_s;
  logic          legal_s;
  logic          writes_rd_s;
  logic          updates_c_s;

  function automatic logic op_legal(input logic [3:0] op);
    logic ok;
`ifdef ALU_ISSUE_CMP_EN
    ok = (op <= OP_CMP);
`else
    ok = (op <= OP_XOR);
`endif
    return ok;
  endfunction

  alu_regfile #(
    .N     (N),
    .NREGS (NREGS),
    .RW    (RW)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (rf_we_s),
    .waddr    (rd_r),
    .wdata    (alu_out),
    .raddr_a  (instr_ra),
    .rdata_a  (rf_rdata_a_s),
    .raddr_b  (instr_rb),
    .rdata_b  (rf_rdata_b_s),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  assign instr_ready = (state_r == S_IDLE);
  assign accept_s    = instr_valid & instr_ready;
  assign legal_s     = op_legal(instr_op);

  // Decode of the in-flight op used during CAPTURE
  always_comb begin
    writes_rd_s = 1'b1;
    updates_c_s = 1'b0;
    case (op_r)
      OP_ADD, OP_SUB: begin
        updates_c_s = 1'b1;
      end
      OP_CMP: begin
        writes_rd_s = 1'b0;
        updates_c_s = 1'b1;
      end
      default: begin
        // Logic ops: the ALU carry output is stale, keep flag_c.
        updates_c_s = 1'b0;
      end
    endcase
  end

  assign rf_we_s = (state_r == S_CAPTURE) && writes_rd_s;

  // Issue FSM, registered ALU request, writeback report and flags.
  // The ALU request is loaded on the accepting edge from the operands
  // visible in IDLE, so it is presented throughout ISSUE; any write from
  // the previous instruction has already landed by then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      op_r        <= 4'd0;
      rd_r        <= {RW{1'b0}};
      alu_enable  <= 1'b0;
      alu_mode    <= 4'd0;
      alu_a       <= {N{1'b0}};
      alu_b       <= {N{1'b0}};
      wb_valid    <= 1'b0;
      wb_rd       <= {RW{1'b0}};
      wb_data     <= {N{1'b0}};
      flag_z      <= 1'b0;
      flag_c      <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      alu_enable  <= 1'b0;
      wb_valid    <= 1'b0;
      err_illegal <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            if (legal_s) begin
              op_r       <= instr_op;
              rd_r       <= instr_rd;
              alu_enable <= 1'b1;
              alu_mode   <= op_to_mode(instr_op);
              alu_a      <= rf_rdata_a_s;
              alu_b      <= instr_use_imm ? instr_imm : rf_rdata_b_s;
              state_r    <= S_ISSUE;
            end else begin
              err_illegal <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          state_r <= S_CAPTURE;
        end
        S_CAPTURE: begin
          flag_z <= alu_zero;
          if (updates_c_s) begin
            flag_c <= alu_carry;
          end
          if (writes_rd_s) begin
            wb_valid <= 1'b1;
            wb_rd    <= rd_r;
            wb_data  <= alu_out;
          end
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Directed testbench for alu_issue with a behavioural 8-bit ALU attached.
module tb_alu_issue;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid;
  logic       instr_ready;
  logic [3:0] instr_op;
  logic [1:0] instr_rd, instr_ra, instr_rb;
  logic       instr_use_imm;
  logic [7:0] instr_imm;
  logic       alu_enable;
  logic [3:0] alu_mode;
  logic [7:0] alu_a, alu_b;
  logic [7:0] alu_out;
  logic       alu_zero, alu_carry;
  logic       wb_valid;
  logic [1:0] wb_rd;
  logic [7:0] wb_data;
  logic       flag_z, flag_c;
  logic       err_illegal;
  logic [1:0] dbg_addr;
  logic [7:0] dbg_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_issue #(.N(8), .NREGS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_ra(instr_ra), .instr_rb(instr_rb),
    .instr_use_imm(instr_use_imm), .instr_imm(instr_imm),
    .alu_enable(alu_enable), .alu_mode(alu_mode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .flag_z(flag_z), .flag_c(flag_c), .err_illegal(err_illegal),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // ALU: registers result/flags on the edge where alu_enable is high.
  // Logic ops return carry 0, so a controller that wrongly copies carry
  // on AND/OR/XOR clears flag_c.
  function automatic logic [9:0] alu_fn(input logic [3:0] m, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] r;
    case (m)
      4'd0:    r = {1'b0, a} + {1'b0, b};
      4'd1:    r = {1'b0, a} - {1'b0, b};
      4'd2:    r = {1'b0, a & b};
      4'd3:    r = {1'b0, a | b};
      4'd4:    r = {1'b0, a ^ b};
      default: r = 9'd0;
    endcase
    return {(r[7:0] == 8'h00), r[8], r[7:0]};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_out   <= 8'h00;
      alu_zero  <= 1'b0;
      alu_carry <= 1'b0;
    end else if (alu_enable) begin
      {alu_zero, alu_carry, alu_out} <= alu_fn(alu_mode, alu_a, alu_b);
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input logic [1:0] a, input logic [7:0] exp);
    dbg_addr = a;
    #1;
    chk($sformatf("reg%0d", a), {8'h00, dbg_data}, {8'h00, exp});
  endtask

  // Runs one legal instruction through IDLE/ISSUE/CAPTURE and checks each phase.
  task automatic run_instr(input string nm, input logic [3:0] op, input logic [1:0] rd,
                           input logic [1:0] ra, input logic [1:0] rb, input logic ui,
                           input logic [7:0] imm, input logic [3:0] exp_mode,
                           input logic [7:0] exp_a, input logic [7:0] exp_b,
                           input logic exp_wb, input logic [7:0] exp_data,
                           input logic exp_z, input logic exp_c);
    @(negedge clk);
    chk({nm, "_ready_idle"}, {15'd0, instr_ready}, 16'd1);
    instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_ra = ra; instr_rb = rb;
    instr_use_imm = ui; instr_imm = imm;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk({nm, "_issue_en"},    {15'd0, alu_enable}, 16'd1);
    chk({nm, "_issue_ready"}, {15'd0, instr_ready}, 16'd0);
    chk({nm, "_issue_mode"},  {12'd0, alu_mode}, {12'd0, exp_mode});
    chk({nm, "_issue_a"},     {8'd0, alu_a}, {8'd0, exp_a});
    chk({nm, "_issue_b"},     {8'd0, alu_b}, {8'd0, exp_b});
    @(posedge clk); #1;
    chk({nm, "_cap_en"},    {15'd0, alu_enable}, 16'd0);
    chk({nm, "_cap_ready"}, {15'd0, instr_ready}, 16'd0);
    chk({nm, "_cap_wb"},    {15'd0, wb_valid}, 16'd0);
    @(posedge clk); #1;
    chk({nm, "_wb_valid"}, {15'd0, wb_valid}, {15'd0, exp_wb});
    if (exp_wb) begin
      chk({nm, "_wb_rd"},   {14'd0, wb_rd}, {14'd0, rd});
      chk({nm, "_wb_data"}, {8'd0, wb_data}, {8'd0, exp_data});
    end
    chk({nm, "_flag_z"},     {15'd0, flag_z}, {15'd0, exp_z});
    chk({nm, "_flag_c"},     {15'd0, flag_c}, {15'd0, exp_c});
    chk({nm, "_ready_back"}, {15'd0, instr_ready}, 16'd1);
  endtask

  // Offers an opcode that must be rejected and checks nothing else moves.
  task automatic run_illegal(input string nm, input logic [3:0] op, input logic exp_z, input logic exp_c);
    @(negedge clk);
    instr_valid = 1'b1; instr_op = op; instr_rd = 2'd0; instr_ra = 2'd1; instr_rb = 2'd2;
    instr_use_imm = 1'b1; instr_imm = 8'h33;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk({nm, "_err"},   {15'd0, err_illegal}, 16'd1);
    chk({nm, "_en"},    {15'd0, alu_enable}, 16'd0);
    chk({nm, "_ready"}, {15'd0, instr_ready}, 16'd1);
    @(posedge clk); #1;
    chk({nm, "_err_pulse"}, {15'd0, err_illegal}, 16'd0);
    chk({nm, "_en2"},       {15'd0, alu_enable}, 16'd0);
    chk({nm, "_wb"},        {15'd0, wb_valid}, 16'd0);
    chk({nm, "_flag_z"},    {15'd0, flag_z}, {15'd0, exp_z});
    chk({nm, "_flag_c"},    {15'd0, flag_c}, {15'd0, exp_c});
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr_op = 4'd0; instr_rd = 2'd0; instr_ra = 2'd0;
    instr_rb = 2'd0; instr_use_imm = 1'b0; instr_imm = 8'h00; dbg_addr = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    chk("rst_ready", {15'd0, instr_ready}, 16'd1);
    chk("rst_en",    {15'd0, alu_enable}, 16'd0);
    chk("rst_mode",  {12'd0, alu_mode}, 16'd0);
    chk("rst_a",     {8'd0, alu_a}, 16'd0);
    chk("rst_b",     {8'd0, alu_b}, 16'd0);
    chk("rst_wb",    {15'd0, wb_valid}, 16'd0);
    chk("rst_err",   {15'd0, err_illegal}, 16'd0);
    chk("rst_fz",    {15'd0, flag_z}, 16'd0);
    chk("rst_fc",    {15'd0, flag_c}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD r1 = r0 + 0x05
    run_instr("add_imm", 4'd0, 2'd1, 2'd0, 2'd0, 1'b1, 8'h05, 4'd0, 8'h00, 8'h05, 1'b1, 8'h05, 1'b0, 1'b0);
    chk_reg(2'd1, 8'h05);
    // ADD r2 = r1 + 0xFF -> 0x04 with carry
    run_instr("add_carry", 4'd0, 2'd2, 2'd1, 2'd0, 1'b1, 8'hFF, 4'd0, 8'h05, 8'hFF, 1'b1, 8'h04, 1'b0, 1'b1);
    // AND r3 = r1 & 0x00 -> zero, carry preserved
    run_instr("and_zero", 4'd2, 2'd3, 2'd1, 2'd0, 1'b1, 8'h00, 4'd2, 8'h05, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1);
    // SUB r1 = r1 - 0x06 -> 0xFF with borrow (same register as source and destination)
    run_instr("sub_borrow", 4'd1, 2'd1, 2'd1, 2'd0, 1'b1, 8'h06, 4'd1, 8'h05, 8'h06, 1'b1, 8'hFF, 1'b0, 1'b1);
    // XOR r0 = r1 ^ r2 (register B operand); carry preserved
    run_instr("xor_reg", 4'd4, 2'd0, 2'd1, 2'd2, 1'b0, 8'hAA, 4'd4, 8'hFF, 8'h04, 1'b1, 8'hFB, 1'b0, 1'b1);
    // OR r3 = r0 | r2 -> 0xFF
    run_instr("or_reg", 4'd3, 2'd3, 2'd0, 2'd2, 1'b0, 8'h00, 4'd3, 8'hFB, 8'h04, 1'b1, 8'hFF, 1'b0, 1'b1);
    // SUB r3 = r2 - r2 -> zero, no borrow
    run_instr("sub_self", 4'd1, 2'd3, 2'd2, 2'd2, 1'b0, 8'h00, 4'd1, 8'h04, 8'h04, 1'b1, 8'h00, 1'b1, 1'b0);
    chk_reg(2'd0, 8'hFB);
    chk_reg(2'd1, 8'hFF);
    chk_reg(2'd2, 8'h04);
    chk_reg(2'd3, 8'h00);
    // ALU request holds its last value while idle
    chk("hold_mode", {12'd0, alu_mode}, 16'd1);
    chk("hold_a",    {8'd0, alu_a}, 16'h0004);

    // Illegal opcode 7: dropped, nothing changes
    run_illegal("ill7", 4'd7, 1'b1, 1'b0);
    chk_reg(2'd0, 8'hFB);
    chk_reg(2'd1, 8'hFF);
    chk("ill7_hold_b", {8'd0, alu_b}, 16'h0004);
`ifndef ALU_ISSUE_CMP_EN
    // Without the feature, CMP is illegal as well
    run_illegal("ill5", 4'd5, 1'b1, 1'b0);
`endif

    // Reset during CAPTURE: in-flight ADD r0 = r1 + 1 dropped
    @(negedge clk);
    instr_valid = 1'b1; instr_op = 4'd0; instr_rd = 2'd0; instr_ra = 2'd1;
    instr_use_imm = 1'b1; instr_imm = 8'h01;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk("mid_issue_en", {15'd0, alu_enable}, 16'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wb", {15'd0, wb_valid}, 16'd0);
    @(posedge clk); #1;
    chk("mid_rst_wb2", {15'd0, wb_valid}, 16'd0);
    chk("mid_rst_fz",  {15'd0, flag_z}, 16'd0);
    chk("mid_rst_fc",  {15'd0, flag_c}, 16'd0);
    for (int i = 0; i < 4; i++) begin
      chk_reg(i[1:0], 8'h00);
    end
    @(negedge clk);
    rst_n = 1'b1;

`ifdef ALU_ISSUE_CMP_EN
    // CMP r1(0x05) vs 0x05: flags only, no writeback
    run_instr("load5", 4'd0, 2'd1, 2'd0, 2'd0, 1'b1, 8'h05, 4'd0, 8'h00, 8'h05, 1'b1, 8'h05, 1'b0, 1'b0);
    run_instr("cmp_eq", 4'd5, 2'd2, 2'd1, 2'd0, 1'b1, 8'h05, 4'd1, 8'h05, 8'h05, 1'b0, 8'h00, 1'b1, 1'b0);
    chk_reg(2'd2, 8'h00);
    run_instr("cmp_lt", 4'd5, 2'd3, 2'd1, 2'd0, 1'b1, 8'h09, 4'd1, 8'h05, 8'h09, 1'b0, 8'h00, 1'b0, 1'b1);
    chk_reg(2'd3, 8'h00);
`else
    // After reset a fresh instruction reads the cleared file
    run_instr("post_rst", 4'd0, 2'd2, 2'd1, 2'd0, 1'b1, 8'h80, 4'd0, 8'h00, 8'h80, 1'b1, 8'h80, 1'b0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
